// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, taken-branch flush,
// load-use stall, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wb_en,
  input  logic        ex_read_en,
  input  logic        ex_brunch_taken,
  input  logic        mem_read_en,
  input  logic        mem_update_en,
  input  logic        dmem_ready,
  input  logic        cnt_clr,
  output logic        dmem_req,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        mem_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

  localparam logic [4:0]  WCNT_LAST = 5'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_t      state_q, state_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_events_q, flush_events_d;

  logic mem_op_s, in_wait_s, freeze_s, timeout_s, branch_s, load_use_s;
  logic rs1_hit_s, rs2_hit_s;

  // Hazard classification; ex_rd != 0 keeps x0 reads from ever stalling.
  always_comb begin
    mem_op_s   = mem_read_en | mem_update_en;
    in_wait_s  = (state_q == MWAIT);
    timeout_s  = in_wait_s & ~dmem_ready & (wcnt_q == WCNT_LAST);
    freeze_s   = (~in_wait_s & mem_op_s & ~dmem_ready) |
                 (in_wait_s & ~dmem_ready & (wcnt_q != WCNT_LAST));
    branch_s   = ~freeze_s & ~timeout_s & ex_brunch_taken;
    rs1_hit_s  = id_rs1_used & (id_rs1 == ex_rd);
    rs2_hit_s  = id_rs2_used & (id_rs2 == ex_rd);
    load_use_s = ~freeze_s & ~timeout_s & ~ex_brunch_taken & ex_read_en & ex_wb_en &
                 (ex_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);
  end

  always_comb begin
    dmem_req     = 1'b0;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    mem_err      = 1'b0;
    if (rst) begin
      dmem_req = 1'b0;
    end else begin
      dmem_req = in_wait_s ? 1'b1 : mem_op_s;
      if (timeout_s) begin
        memwb_bubble = 1'b1;
        mem_err      = 1'b1;
      end else if (freeze_s) begin
        pc_hold      = 1'b1;
        ifid_hold    = 1'b1;
        idex_hold    = 1'b1;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
      end else if (branch_s) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use_s) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_hold = 1'b0;
      end
    end
  end

  // A timeout abandons the access, so MWAIT always returns to RUN on ready or timeout.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (mem_op_s & ~dmem_ready) begin
          state_d = MWAIT;
          wcnt_d  = 5'd0;
        end else begin
          state_d = RUN;
        end
      end
      MWAIT: begin
        if (dmem_ready | timeout_s) begin
          state_d = RUN;
          wcnt_d  = 5'd0;
        end else begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 5'd0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (cnt_clr) begin
      stall_cycles_d = 16'd0;
      flush_events_d = 16'd0;
    end else begin
      if (pc_hold && (stall_cycles_q != CNT_MAX)) begin
        stall_cycles_d = stall_cycles_q + 16'd1;
      end else begin
        stall_cycles_d = stall_cycles_q;
      end
      if (ifid_flush && (flush_events_q != CNT_MAX)) begin
        flush_events_d = flush_events_q + 16'd1;
      end else begin
        flush_events_d = flush_events_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wcnt_q         <= 5'd0;
      stall_cycles_q <= 16'd0;
      flush_events_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_wb_en, ex_read_en, ex_brunch_taken;
  logic        mem_read_en, mem_update_en, dmem_ready, cnt_clr;
  logic        dmem_req, pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic        ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [15:0] stall_cycles, flush_events;
  logic [8:0]  outs;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // {dmem_req, pc, ifid, idex, exmem hold, ifid_flush, idex_flush, bubble, err}
  localparam logic [8:0] O_NONE = 9'b0_0000_00_0_0;
  localparam logic [8:0] O_LU   = 9'b0_1100_01_0_0;
  localparam logic [8:0] O_BR   = 9'b0_0000_11_0_0;
  localparam logic [8:0] O_FRZ  = 9'b1_1111_00_1_0;
  localparam logic [8:0] O_REL  = 9'b1_0000_00_0_0;
  localparam logic [8:0] O_TO   = 9'b1_0000_00_1_1;

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_read_en(ex_read_en),
    .ex_brunch_taken(ex_brunch_taken),
    .mem_read_en(mem_read_en), .mem_update_en(mem_update_en),
    .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .dmem_req(dmem_req), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign outs = {dmem_req, pc_hold, ifid_hold, idex_hold, exmem_hold,
                 ifid_flush, idex_flush, memwb_bubble, mem_err};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_wb_en = 1'b0; ex_read_en = 1'b0; ex_brunch_taken = 1'b0;
    mem_read_en = 1'b0; mem_update_en = 1'b0; dmem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_lu();
    ex_read_en = 1'b1; ex_wb_en = 1'b1; ex_rd = 5'd5;
    id_rs2_used = 1'b1; id_rs2 = 5'd5;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1'b1; mem_read_en = 1'b1; ex_brunch_taken = 1'b1;
    tick();
    check_val("rst_outs", {23'd0, outs}, {23'd0, O_NONE});
    tick();
    check_val("rst_stall", {16'd0, stall_cycles}, 32'd0);
    check_val("rst_flush", {16'd0, flush_events}, 32'd0);
    rst = 1'b0; clear_in(); #1;
    check_val("idle", {23'd0, outs}, {23'd0, O_NONE});

    set_lu(); #1;
    check_val("lu_rs2", {23'd0, outs}, {23'd0, O_LU});
    tick();
    check_val("lu_stall1", {16'd0, stall_cycles}, 32'd1);
    clear_in(); ex_read_en = 1'b1; ex_wb_en = 1'b1; ex_rd = 5'd9;
    id_rs1_used = 1'b1; id_rs1 = 5'd9; #1;
    check_val("lu_rs1", {23'd0, outs}, {23'd0, O_LU});
    tick();
    check_val("lu_stall2", {16'd0, stall_cycles}, 32'd2);

    clear_in(); ex_read_en = 1'b1; ex_wb_en = 1'b1; id_rs1_used = 1'b1; #1;
    check_val("x0_nostall", {23'd0, outs}, {23'd0, O_NONE});
    set_lu(); ex_wb_en = 1'b0; #1;
    check_val("nowb_nostall", {23'd0, outs}, {23'd0, O_NONE});
    set_lu(); ex_read_en = 1'b0; #1;
    check_val("noload_nostall", {23'd0, outs}, {23'd0, O_NONE});
    set_lu(); id_rs2_used = 1'b0; #1;
    check_val("unused_nostall", {23'd0, outs}, {23'd0, O_NONE});

    set_lu(); ex_brunch_taken = 1'b1; #1;
    check_val("br_over_lu", {23'd0, outs}, {23'd0, O_BR});
    tick();
    check_val("br_flush1", {16'd0, flush_events}, 32'd1);
    check_val("br_stall_same", {16'd0, stall_cycles}, 32'd2);

    clear_in(); mem_read_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      ex_brunch_taken = (c == 3); #1;
      check_val($sformatf("mwait_frz%0d", c), {23'd0, outs}, {23'd0, O_FRZ});
      tick();
    end
    ex_brunch_taken = 1'b0; dmem_ready = 1'b1; #1;
    check_val("mwait_release", {23'd0, outs}, {23'd0, O_REL});
    tick();
    check_val("mwait_stall", {16'd0, stall_cycles}, 32'd5);
    check_val("mwait_noflush", {16'd0, flush_events}, 32'd1);
    clear_in(); #1;
    check_val("mwait_back_run", {23'd0, outs}, {23'd0, O_NONE});

    mem_update_en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check_val($sformatf("to_frz%0d", c), {23'd0, outs}, {23'd0, O_FRZ});
      tick();
    end
    check_val("to_pulse", {23'd0, outs}, {23'd0, O_TO});
    tick();
    clear_in(); #1;
    check_val("to_back_run", {23'd0, outs}, {23'd0, O_NONE});
    check_val("to_stall", {16'd0, stall_cycles}, 32'd9);

    mem_read_en = 1'b1; #1;
    check_val("rmw_frz", {23'd0, outs}, {23'd0, O_FRZ});
    tick();
    rst = 1'b1; #1;
    check_val("rmw_rst_outs", {23'd0, outs}, {23'd0, O_NONE});
    tick();
    rst = 1'b0; mem_read_en = 1'b0; #1;
    check_val("rmw_run", {23'd0, outs}, {23'd0, O_NONE});
    check_val("rmw_stall0", {16'd0, stall_cycles}, 32'd0);
    mem_read_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check_val($sformatf("rmw_frz%0d", c), {23'd0, outs}, {23'd0, O_FRZ});
      tick();
    end
    dmem_ready = 1'b1; #1;
    check_val("rmw_release", {23'd0, outs}, {23'd0, O_REL});
    tick();
    check_val("rmw_stall3", {16'd0, stall_cycles}, 32'd3);

    clear_in(); ex_brunch_taken = 1'b1; tick();
    check_val("clr_pre_flush", {16'd0, flush_events}, 32'd1);
    clear_in(); set_lu(); cnt_clr = 1'b1; #1;
    check_val("clr_lu_outs", {23'd0, outs}, {23'd0, O_LU});
    tick();
    check_val("clr_stall", {16'd0, stall_cycles}, 32'd0);
    check_val("clr_flush", {16'd0, flush_events}, 32'd0);

    cnt_clr = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    check_val("sat_reach", {16'd0, stall_cycles}, 32'h0000FFFF);
    tick(); tick();
    check_val("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
    cnt_clr = 1'b1; tick();
    check_val("sat_clr", {16'd0, stall_cycles}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16 (range 2..31), max cycles spent in MWAIT before abort.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous and active-high.
- id_rs1, id_rs2  in  5 each  ID-stage source register numbers.
- id_rs1_used, id_rs2_used  in  1 each  ID instruction reads rs1 / rs2.
- ex_rd  in  5  EX-stage destination register.
- ex_wb_en  in  1  EX instruction writes back.
- ex_read_en  in  1  EX instruction is a load.
- ex_brunch_taken  in  1  EX resolved a taken branch.
- mem_read_en, mem_update_en  in  1 each  MEM-stage load / store.
- dmem_ready  in  1  data-memory completion.
- cnt_clr  in  1  clear performance counters.
- dmem_req  out  1  data-memory request.
- pc_hold, ifid_hold, idex_hold, exmem_hold  out  1 each  hold the corresponding register.
- ifid_flush, idex_flush  out  1 each  load a bubble into the corresponding register.
- memwb_bubble  out  1  MEM/WB captures a bubble; drives the downstream stall / s_flag.
- mem_err  out  1  one-cycle pulse on memory timeout.
- stall_cycles, flush_events  out  16 each  saturating performance counters.

Function
REQ-003 The FSM SHALL have two states, RUN and MWAIT, plus a 5-bit wait counter wcnt.
REQ-004 mem_op SHALL be defined as mem_read_en | mem_update_en.
REQ-005 In RUN, dmem_req SHALL equal mem_op, combinationally.
REQ-006 In MWAIT, dmem_req SHALL be held at 1.
REQ-007 freeze SHALL be asserted when any of the following holds:
- RUN, mem_op=1 and dmem_ready=0;
- MWAIT and dmem_ready=0 and wcnt != TIMEOUT-1.
REQ-008 Freeze outputs:
- freeze=1: pc_hold, ifid_hold, idex_hold, exmem_hold and memwb_bubble SHALL all be 1.
- freeze=1: ifid_flush and idex_flush SHALL be 0.
REQ-009 FSM transitions and wcnt:
- RUN to MWAIT on mem_op & !dmem_ready; wcnt is set to 0.
- MWAIT to RUN on dmem_ready=1, with freeze=0 in that same cycle.
- MWAIT with !dmem_ready SHALL increment wcnt.
REQ-010 Timeout: in MWAIT with wcnt==TIMEOUT-1 and dmem_ready=0:
- mem_err=1 for that cycle;
- freeze=0 for that cycle;
- next state RUN; the MEM instruction retires as a bubble (memwb_bubble=1).
REQ-011 If freeze=0 and ex_brunch_taken=1:
- ifid_flush=1 and idex_flush=1;
- load-use detection is suppressed that cycle.
REQ-012 Load-use condition: freeze=0, ex_brunch_taken=0, ex_read_en=1, ex_wb_en=1, ex_rd != 0, and either (id_rs1_used & id_rs1==ex_rd) or (id_rs2_used & id_rs2==ex_rd).
REQ-013 When the load-use condition holds:
- pc_hold=1, ifid_hold=1, idex_flush=1;
- all other hold/flush outputs SHALL be 0.
REQ-014 Priority SHALL be timeout/freeze, then branch flush, then load-use. All outputs SHALL be 0 when no condition applies.
REQ-015 stall_cycles SHALL increment by 1 on each cycle with pc_hold=1.
REQ-016 flush_events SHALL increment by 1 on each cycle with ifid_flush=1.
REQ-017 Both counters SHALL saturate at 16'hFFFF.
REQ-018 cnt_clr=1 SHALL zero both counters on the next edge; clear takes precedence over increment.
REQ-019 A register read of x0 (rs==0) SHALL never cause a load-use stall.
REQ-020 Latency: all hold, flush, dmem_req and mem_err outputs SHALL be combinational from the inputs and the current state, so they take effect in the same cycle.

Reset
REQ-021 On a clock edge with rst=1, the block SHALL reset to: state=RUN, wcnt=0, stall_cycles=0, flush_events=0.
REQ-022 While rst=1, all hold, flush, dmem_req, memwb_bubble and mem_err outputs SHALL be 0.
REQ-023 Reset asserted during MWAIT SHALL abandon the access without a mem_err pulse; the block then resumes in RUN.

Verification
REQ-024 Load-use stall:
- Stimulus: ex_read_en=1, ex_wb_en=1, ex_rd=5, id_rs2_used=1, id_rs2=5.
- Response: pc_hold=ifid_hold=idex_flush=1 for 1 cycle; stall_cycles becomes 1.
REQ-025 Branch with concurrent load-use:
- Stimulus: ex_brunch_taken=1 while the load-use condition also holds.
- Response: only ifid_flush=idex_flush=1; flush_events +1; stall_cycles unchanged.
REQ-026 Memory wait:
- Stimulus: mem_read_en=1; dmem_ready goes high on the 4th cycle.
- Response: freeze held for 3 cycles; the FSM is in MWAIT from cycle 2; outputs release in cycle 4; dmem_req=1 for all 4 cycles; stall_cycles=3.
REQ-027 Memory timeout:
- Stimulus: TIMEOUT=4, mem_update_en=1, dmem_ready never asserted.
- Response: freeze for cycles 1-4; mem_err pulse in cycle 5; state returns to RUN.
REQ-028 Counter saturation and clear:
- Preload stall_cycles to 16'hFFFF, then continue stalling; the counter holds at FFFF.
- Assert cnt_clr together with pc_hold; the counter reads 0 next cycle.
REQ-029 Reset mid-wait:
- Stimulus: rst=1 in the 2nd MWAIT cycle.
- Response: all outputs 0 and no mem_err; the next access behaves per REQ-026.
